// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CHK state exists only when LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Opcode field of the halt instruction that test programs end with.
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_e;

    // True while a frame is being received: bytes are accepted and the idle timer runs.
    function automatic logic is_loading(input state_e s);
        return !(s inside {S_IDLE, S_DONE, S_ERR});
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a big-endian byte stream into 32-bit words.
// word_valid_o is combinational and pulses on the byte that completes a word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_stb_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] sr_q;

    assign word_valid_o = byte_stb_i && (cnt_q == 2'(WORD_BYTES - 1));
    assign word_o       = {sr_q, byte_i};

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (byte_stb_i) begin
            cnt_q <= cnt_q + 2'd1;
            sr_q  <= {sr_q[15:0], byte_i};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a counted byte frame, writes words from address 0,
// holds the core in reset until the load completes. Optional checksum: LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] DEPTH = 17'(1 << ADDR_W);
`ifdef LOADER_CHECKSUM_EN
    localparam state_e S_LAST = S_CHK;
`else
    localparam state_e S_LAST = S_DONE;
`endif

    state_e            state_q, state_d;
    logic              ready_q, we_q, core_rst_q, done_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       cnt_q;
    logic [15:0]       idx_q;
    logic [31:0]       tmo_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    logic        xfer, start, active, byte_stb, word_valid;
    logic [31:0] word;
    logic [15:0] n_rx;

    assign xfer     = in_valid & ready_q;
    assign active   = is_loading(state_q);
    assign start    = load_req && !active;
    assign byte_stb = xfer && (state_q == S_DATA);
    assign n_rx     = {cnt_q[15:8], in_data};

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start),
        .byte_stb_i   (byte_stb),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (load_req) state_d = S_CNT_HI;
            S_CNT_HI: if (xfer) state_d = S_CNT_LO;
            S_CNT_LO: begin
                if (xfer) begin
                    if ({1'b0, n_rx} > DEPTH) state_d = S_ERR;
                    else if (n_rx == 16'd0)   state_d = S_LAST;
                    else                      state_d = S_DATA;
                end
            end
            S_DATA: if (word_valid && (idx_q == cnt_q - 16'd1)) state_d = S_LAST;
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (xfer) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
        // Without a transfer no loading state can advance, so the timeout never races a transition.
        if (TIMEOUT_CYC != 0 && active && !xfer && tmo_q == TIMEOUT_CYC - 1) state_d = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= is_loading(state_d);
            we_q    <= 1'b0;

            if (start) begin
                core_rst_q <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                cnt_q      <= '0;
                idx_q      <= '0;
                tmo_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
                chk_q      <= '0;
`endif
            end else begin
                if (state_q == S_DONE) begin
                    done_q     <= 1'b1;
                    core_rst_q <= 1'b0;
                end
                if (state_q == S_ERR) err_q <= 1'b1;
            end

            if (xfer)        tmo_q <= '0;
            else if (active) tmo_q <= tmo_q + 32'd1;

            if (xfer && state_q == S_CNT_HI) cnt_q[15:8] <= in_data;
            if (xfer && state_q == S_CNT_LO) cnt_q[7:0]  <= in_data;

`ifdef LOADER_CHECKSUM_EN
            if (xfer && state_q != S_CHK) chk_q <= chk_q ^ in_data;
`endif

            if (word_valid) begin
                we_q    <= 1'b1;
                addr_q  <= idx_q[ADDR_W-1:0];
                wdata_q <= word;
                idx_q   <= idx_q + 16'd1;
            end
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random frames against a frame-level reference model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_req = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready, imem_we, core_rst, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] frame_words [0:DEPTH-1];
    logic [7:0]  tx[$];
    logic [7:0]  tx_xor;
    int          xfer_cyc[$];
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    endtask

    task automatic start_load();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    // Frame = 16-bit count, count words MSB first, plus checksum byte when that build is active.
    task automatic build_frame(input int n_hdr, input int n_words);
        logic [15:0] n16;
        n16 = 16'(n_hdr);
        tx.delete(); xfer_cyc.delete();
        tx.push_back(n16[15:8]);
        tx.push_back(n16[7:0]);
        for (int i = 0; i < n_words; i++)
            for (int b = 3; b >= 0; b--) tx.push_back(frame_words[i][8*b +: 8]);
        tx_xor = 8'h00;
        foreach (tx[k]) tx_xor = tx_xor ^ tx[k];
`ifdef LOADER_CHECKSUM_EN
        if (n_hdr <= DEPTH) tx.push_back(tx_xor);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && waited < 40) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                xfer_cyc.push_back(cyc);
            end else begin
                @(posedge clk); #1;
                waited++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input int max_gap, output bit ok);
        ok = 1'b1;
        for (int k = first; k <= last && ok; k++) begin
            send_byte(tx[k], ok);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_end(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done === 1'b1 || err === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (imem_we !== 1'b0)    begin fails++; $display("FAIL reset_we got=%b exp=0", imem_we); end
        checks++; if (imem_addr !== '0)    begin fails++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        checks++; if (imem_wdata !== '0)   begin fails++; $display("FAIL reset_wdata got=%h exp=0", imem_wdata); end
        checks++; if (core_rst !== 1'b1)   begin fails++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
        checks++; if (done !== 1'b0)       begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0)        begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_two_words();
        bit ok, got;
        int w0, w1;
        clear_log();
        frame_words[0] = 32'h0000_0001;
        frame_words[1] = {HALT_OPCODE, 26'd0};
        build_frame(2, 2);
        start_load();
        send_range(0, tx.size() - 1, 0, ok);
        wait_end(got);
        w0 = HDR_BYTES + WORD_BYTES - 1;
        w1 = w0 + WORD_BYTES;
        checks++; if (!ok || !got) begin fails++; $display("FAIL two_words_handshake ok=%0d end=%0d exp=1,1", ok, got); end
        checks++; if (wr_addr.size() != 2) begin fails++; $display("FAIL two_words_count got=%0d exp=2", wr_addr.size()); end
        if (wr_addr.size() == 2 && xfer_cyc.size() > w1) begin
            checks++; if (wr_addr[0] != 0 || wr_data[0] !== 32'h0000_0001)
                begin fails++; $display("FAIL two_words_w0 got=%0d:%h exp=0:00000001", wr_addr[0], wr_data[0]); end
            checks++; if (wr_addr[1] != 1 || wr_data[1] !== 32'hFC00_0000)
                begin fails++; $display("FAIL two_words_w1 got=%0d:%h exp=1:fc000000", wr_addr[1], wr_data[1]); end
            checks++; if (wr_cyc[0] != xfer_cyc[w0] || wr_cyc[1] != xfer_cyc[w1])
                begin fails++; $display("FAIL two_words_latency got=%0d,%0d exp=%0d,%0d", wr_cyc[0], wr_cyc[1], xfer_cyc[w0], xfer_cyc[w1]); end
            checks++; if (wr_cyc[1] - wr_cyc[0] != 4)
                begin fails++; $display("FAIL two_words_spacing got=%0d exp=4", wr_cyc[1] - wr_cyc[0]); end
        end
        checks++; if (done !== 1'b1 || core_rst !== 1'b0 || err !== 1'b0)
            begin fails++; $display("FAIL two_words_status done=%b core_rst=%b err=%b exp=1,0,0", done, core_rst, err); end
    endtask

    task automatic test_zero_count();
        bit ok, got;
        clear_log();
        build_frame(0, 0);
        start_load();
        checks++; if (done !== 1'b0 || core_rst !== 1'b1)
            begin fails++; $display("FAIL zero_restart done=%b core_rst=%b exp=0,1", done, core_rst); end
`ifdef LOADER_CHECKSUM_EN
        send_range(0, tx.size() - 1, 0, ok);
        wait_end(got);
        checks++; if (!ok || done !== 1'b1) begin fails++; $display("FAIL zero_done got=%b exp=1", done); end
`else
        send_range(0, 1, 0, ok);
        checks++; if (!ok || done !== 1'b0) begin fails++; $display("FAIL zero_done_early got=%b exp=0", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || core_rst !== 1'b0)
            begin fails++; $display("FAIL zero_done_t2 done=%b core_rst=%b exp=1,0", done, core_rst); end
`endif
        // Bytes offered after completion must not be taken.
        in_valid = 1'b1; in_data = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL zero_idle_ready got=%b exp=0", in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (wr_addr.size() != 0) begin fails++; $display("FAIL zero_writes got=%0d exp=0", wr_addr.size()); end
    endtask

    task automatic test_oversize();
        bit ok, got;
        int n;
        clear_log();
        build_frame(DEPTH + 1, 0);
        start_load();
        send_range(0, 1, 0, ok);
        wait_end(got);
        checks++; if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0)
            begin fails++; $display("FAIL oversize_status err=%b core_rst=%b done=%b exp=1,1,0", err, core_rst, done); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL oversize_ready got=%b exp=0", in_ready); end
        checks++; if (wr_addr.size() != 0) begin fails++; $display("FAIL oversize_writes got=%0d exp=0", wr_addr.size()); end
        n = 3;
        for (int i = 0; i < n; i++) frame_words[i] = $urandom;
        build_frame(n, n);
        start_load();
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL oversize_err_clear got=%b exp=0", err); end
        send_range(0, tx.size() - 1, 2, ok);
        wait_end(got);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL oversize_reload done=%b err=%b exp=1,0", done, err); end
        checks++; if (wr_addr.size() != n) begin fails++; $display("FAIL oversize_reload_count got=%0d exp=%0d", wr_addr.size(), n); end
    endtask

    task automatic test_random_frames();
        bit ok, got;
        int n, bad;
        for (int it = 0; it < 6; it++) begin
            clear_log();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) frame_words[i] = $urandom;
            build_frame(n, n);
            start_load();
            send_range(0, tx.size() - 1, 3, ok);
            wait_end(got);
            checks++; if (done !== 1'b1 || core_rst !== 1'b0)
                begin fails++; $display("FAIL rand_status it=%0d done=%b core_rst=%b exp=1,0", it, done, core_rst); end
            checks++; if (wr_addr.size() != n) begin fails++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, wr_addr.size(), n); end
            bad = 0;
            for (int i = 0; i < n && i < wr_addr.size(); i++)
                if (wr_addr[i] != i || wr_data[i] !== frame_words[i]) bad++;
            checks++; if (bad != 0) begin fails++; $display("FAIL rand_data it=%0d bad_words=%0d exp=0", it, bad); end
        end
    endtask

    task automatic test_load_req_midload();
        bit ok, got;
        int n, bad;
        clear_log();
        n = 4;
        for (int i = 0; i < n; i++) frame_words[i] = $urandom;
        build_frame(n, n);
        start_load();
        send_range(0, 6, 0, ok);
        start_load();
        send_range(7, tx.size() - 1, 1, ok);
        wait_end(got);
        bad = 0;
        for (int i = 0; i < n && i < wr_addr.size(); i++)
            if (wr_addr[i] != i || wr_data[i] !== frame_words[i]) bad++;
        checks++; if (!ok || done !== 1'b1 || wr_addr.size() != n || bad != 0)
            begin fails++; $display("FAIL midload_req done=%b writes=%0d bad=%0d exp=1,%0d,0", done, wr_addr.size(), bad, n); end
    endtask

    task automatic test_depth();
        bit ok, got;
        int bad;
        clear_log();
        for (int i = 0; i < DEPTH; i++) frame_words[i] = $urandom;
        build_frame(DEPTH, DEPTH);
        start_load();
        send_range(0, tx.size() - 1, 0, ok);
        wait_end(got);
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL depth_done got=%b exp=1", done); end
        checks++; if (wr_addr.size() != DEPTH) begin fails++; $display("FAIL depth_count got=%0d exp=%0d", wr_addr.size(), DEPTH); end
        bad = 0;
        for (int i = 0; i < DEPTH && i < wr_addr.size(); i++)
            if (wr_addr[i] != i || wr_data[i] !== frame_words[i]) bad++;
        checks++; if (bad != 0) begin fails++; $display("FAIL depth_data bad_words=%0d exp=0", bad); end
        if (wr_addr.size() > 0) begin
            checks++; if (wr_addr[wr_addr.size() - 1] != DEPTH - 1)
                begin fails++; $display("FAIL depth_last_addr got=%0d exp=%0d", wr_addr[wr_addr.size() - 1], DEPTH - 1); end
        end
    endtask

    task automatic test_timeout();
        bit ok, got;
        clear_log();
        frame_words[0] = $urandom; frame_words[1] = $urandom;
        build_frame(2, 2);
        start_load();
        send_range(0, HDR_BYTES + 4, 0, ok);
        repeat (TMO - 1) begin @(posedge clk); #1; end
        checks++; if (err !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL timeout_early err=%b in_ready=%b exp=0,1", err, in_ready); end
        wait_end(got);
        checks++; if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0)
            begin fails++; $display("FAIL timeout_err err=%b core_rst=%b done=%b exp=1,1,0", err, core_rst, done); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL timeout_ready got=%b exp=0", in_ready); end
        checks++; if (wr_addr.size() != 1) begin fails++; $display("FAIL timeout_writes got=%0d exp=1", wr_addr.size()); end
    endtask

    task automatic test_rst_midload();
        bit ok, got;
        int bad;
        for (int i = 0; i < 5; i++) frame_words[i] = $urandom;
        build_frame(5, 5);
        start_load();
        send_range(0, HDR_BYTES + 3 * WORD_BYTES + 1, 0, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0)
            begin fails++; $display("FAIL rst_mid_io ready=%b we=%b addr=%h wdata=%h exp=0,0,0,0", in_ready, imem_we, imem_addr, imem_wdata); end
        checks++; if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0)
            begin fails++; $display("FAIL rst_mid_status core_rst=%b done=%b err=%b exp=1,0,0", core_rst, done, err); end
        rst = 1'b0;
        @(posedge clk); #1;
        clear_log();
        frame_words[0] = $urandom; frame_words[1] = $urandom;
        build_frame(2, 2);
        start_load();
        send_range(0, tx.size() - 1, 1, ok);
        wait_end(got);
        bad = 0;
        for (int i = 0; i < 2 && i < wr_addr.size(); i++)
            if (wr_addr[i] != i || wr_data[i] !== frame_words[i]) bad++;
        checks++; if (done !== 1'b1 || wr_addr.size() != 2 || bad != 0)
            begin fails++; $display("FAIL rst_mid_reload done=%b writes=%0d bad=%0d exp=1,2,0", done, wr_addr.size(), bad); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bit ok, got;
        frame_words[0] = 32'h1234_5678;
        build_frame(1, 1);
        checks++; if (tx[tx.size() - 1] !== 8'h09) begin fails++; $display("FAIL chk_model got=%h exp=09", tx[tx.size() - 1]); end
        start_load();
        send_range(0, tx.size() - 1, 0, ok);
        wait_end(got);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL chk_good done=%b err=%b exp=1,0", done, err); end
        tx[tx.size() - 1] = 8'h08;
        start_load();
        send_range(0, tx.size() - 1, 0, ok);
        wait_end(got);
        checks++; if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0)
            begin fails++; $display("FAIL chk_bad err=%b core_rst=%b done=%b exp=1,1,0", err, core_rst, done); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_zero_count();
        test_oversize();
        test_random_frames();
        test_load_req_midload();
        test_depth();
        test_timeout();
        test_rst_midload();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
